// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU family: op encoding and flag bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_SRA = 3'd7
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/pipe_alu_if.sv
// Operand/result bus of pipe_alu: producer side (in_*) and consumer side (out_*).
interface pipe_alu_if #(parameter int WIDTH = 8);
  import alu_pkg::*;

  // A beat moves on a clock edge where valid && ready; valid-side payload must
  // hold steady until that edge, and ready may depend on the consumer's ready.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  alu_op_e          op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic [3:0]       flags;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, z, flags
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, z, flags
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU: eight ops with N/Z/C/V flags; arithmetic done at WIDTH+1 bits.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   sh;
  logic             carry;
  logic             ovf;

  assign sum  = {1'b0, a} + {1'b0, b};
  // The extra bit of the subtraction is the borrow, i.e. a < b unsigned.
  assign diff = {1'b0, a} - {1'b0, b};
  assign sh   = b[SHW-1:0];

  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    unique case (op)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SLL: result = a << sh;
      OP_SRL: result = a >> sh;
      OP_SRA: result = $signed(a) >>> sh;
    endcase

    flags         = '0;
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_C] = carry;
    flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/pipe_alu.sv
// Two-register pipelined ALU: stage 1 latches operands, stage 2 latches result and flags.
module pipe_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic       clk,
  input logic       rst,
  pipe_alu_if.slave bus
);

  logic             v1;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  alu_op_e          op_q;
  logic             out_valid;
  logic [WIDTH-1:0] z;
  logic [3:0]       flags;
  logic [WIDTH-1:0] result;
  logic [3:0]       result_flags;
  logic             s2_free;
  logic             in_ready;

  alu_core #(.WIDTH(WIDTH), .SHW(SHW)) u_core (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (result),
    .flags  (result_flags)
  );

  // Stage 1 may advance whenever stage 2 drains or is empty in the same edge.
  assign s2_free  = !out_valid || bus.out_ready;
  assign in_ready = (!v1 || s2_free) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_ADD;
      out_valid <= 1'b0;
      z         <= '0;
      flags     <= '0;
    end else begin
      if (s2_free) begin
        out_valid <= v1;
        if (v1) begin
          z     <= result;
          flags <= result_flags;
        end
      end
      if (in_ready) begin
        v1 <= bus.in_valid;
        if (bus.in_valid) begin
          a_q  <= bus.a;
          b_q  <= bus.b;
          op_q <= bus.op;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.z         = z;
  assign bus.flags     = flags;

endmodule

// File: doc/pipe_alu.md
# pipe_alu

Parametrised two-register pipelined ALU with valid/ready handshakes on both sides, a configurable data width, eight operations and a four-bit flag output. It is the next generation of the team's 4-bit pipelined ALU. It sits between an operand producer and a result consumer, and it absorbs consumer backpressure without dropping or duplicating operations.

## Interface
- `WIDTH`, default 8: operand/result width, legal range 4..32.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width, derived, not overridden.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: operand beat present.
- `in_ready` out 1: stage 1 can accept a beat this cycle.
- `a`, `b` in `WIDTH`: operands.
- `op` in 3: operation, encoded per `alu_pkg::alu_op_e`.
- `out_valid` out 1: result beat present.
- `out_ready` in 1: consumer accepts a result this cycle.
- `z` out `WIDTH`: result.
- `flags` out 4: bit 3 is N, bit 2 is Z, bit 1 is C, bit 0 is V.

## Operation
- **Stage 1 (input register):** holds `a_q`, `b_q`, `op_q` and `v1`.
- **Compute:** combinational ALU on stage-1 contents.
- **Stage 2 (output register):** holds `z`, `flags` and `out_valid`.
- **Transfers:**
  - Input transfer when `in_valid && in_ready`.
  - Output transfer when `out_valid && out_ready`.
- **Ready terms:**
  - `s2_free = !out_valid || out_ready`.
  - `in_ready = (!v1 || s2_free) && !rst`.
- **Stage 2 update:** stage 2 loads when `s2_free`.
  - `out_valid <= v1`.
  - `z` and `flags` load only when `v1`; otherwise they hold their old values.
- **Stage 1 update:**
  - Loads when `in_ready`: `v1 <= in_valid`; data loads only on an input transfer.
  - Holds when stalled.
- **Ops** (`a` and `b` taken from stage 1):
  - ADD=0: `a+b`.
  - SUB=1: `a-b`.
  - AND=2, OR=3, XOR=4.
  - SLL=5: `a << b[SHW-1:0]`.
  - SRL=6: logical right shift by `b[SHW-1:0]`.
  - SRA=7: arithmetic right shift by `b[SHW-1:0]`.
  - Upper bits of `b` are ignored for shifts.
- **Arithmetic:** computed at `WIDTH+1` bits. The result is the low `WIDTH` bits.
- **Flags:**
  - N = result MSB.
  - Z = result equals 0.
  - C: for ADD, the carry-out. For SUB, the borrow, i.e. `a < b` unsigned. 0 for all other ops.
  - V: signed overflow for ADD/SUB, i.e. operands have equal sign (ADD) or different sign (SUB) and the result sign differs from `a`. 0 for all other ops.
- **Illegal values:** none; all 8 op codes are defined.

## Timing
- **Reset:** with `rst` high at an edge:
  - `v1`, `out_valid`, `a_q`, `b_q`, `op_q`, `z` and `flags` all become 0.
  - `in_ready` is 0 while `rst` is high and 1 in the first cycle after.
- **Reset mid-operation:** in-flight beats are discarded and no partial result appears.
- **Latency:** 2 edges. A beat accepted at edge k has `out_valid` high in the cycle after edge k+1, provided stage 2 is free.
- **Throughput:** 1 beat/cycle while `out_ready` is held high.
- **Full pipeline:**
  - Condition: `v1` and `out_valid` both set and `out_ready` low.
  - `in_ready` is 0 and both stages hold.
  - `z`/`flags` stay stable while `out_valid && !out_ready`.
- **Simultaneous events:** with the pipeline full and `out_ready` rising, one edge:
  - retires stage 2,
  - moves stage 1 into stage 2,
  - accepts a new input if `in_valid` is high.
- **Combinational paths:** `in_ready` depends combinationally on `out_ready` (a single gate path). There is no combinational path from `in_valid` to `out_valid`.
- **Bubbles:** `in_valid` low while `in_ready` is high inserts a bubble. The bubble propagates as `out_valid=0`; `z` holds its last value.

## Structure
- **Package `alu_pkg`:**
  - `alu_op_e` (3-bit enum, values above).
  - Flag bit-index localparams `FLAG_N`=3, `FLAG_Z`=2, `FLAG_C`=1, `FLAG_V`=0.
- **Sub-module `alu_core`:**
  - Purely combinational, parameterised by `WIDTH`.
  - Inputs: `a`, `b`, `op`. Outputs: `result`, `flags`.
  - Reused by future unpipelined variants.
- **Top `pipe_alu`:** handshake logic and the two register stages only.

## Test plan
All scenarios use WIDTH=8.
- **Reset mid-stream:** assert `rst` with both stages full → next cycle `out_valid=0`, `z=0`, `flags=0`, `in_ready=0`. After release, `in_ready=1` and no stale beat emerges.
- **ADD carry:** `a=0xFF`, `b=0x01`, ADD, `out_ready=1` → two edges later `z=0x00`, `flags=4'b0110` (Z, C).
- **SUB overflow and borrow:** `a=0x80`, `b=0x01`, SUB → `z=0x7F`, `flags=4'b0001` (V). Then `a=0x01`, `b=0x02`, SUB → `z=0xFF`, `flags=4'b1010` (N, C).
- **Shifts:** `a=0x90`, `b=0x0B` with SRA → `z=0xF2` (shift by 3, upper bits of `b` ignored). SRL → `z=0x12`. SLL → `z=0x80`, `flags=4'b1000`.
- **Backpressure:** stream 5 ADD beats (`a=i`, `b=1`) with `out_ready` low for cycles 2..5 → `in_ready` drops after 2 accepted beats. Results 1..5 arrive in order, with no loss or duplication. `z` is stable while stalled.
- **Full throughput:** 16 back-to-back XOR beats with `out_ready=1` → 16 consecutive `out_valid` cycles, first result 2 edges after the first accept.
